// File: rtl/gde_pkg.sv
// Shared types and helpers for the gd_quad_engine datapath.
// Holds the FSM state type, the saturation bounds as functions of the word
// width, and sat_trunc, which clamps a wide signed value to a narrower word.
package gde_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRAD,
      S_UPDATE,
      S_EVAL1,
      S_EVAL2,
      S_DONE
   } gde_state_e;

   // Wide carrier for all saturation arithmetic; covers words up to 64 bits.
   localparam int unsigned SAT_ACC_W = 128;
   typedef logic signed [SAT_ACC_W-1:0] gde_acc_t;

   // Largest value representable in a w-bit signed word.
   function automatic gde_acc_t sat_max(input int unsigned w);
      return (gde_acc_t'(1) <<< (w - 1)) - gde_acc_t'(1);
   endfunction

   // Smallest value representable in a w-bit signed word.
   function automatic gde_acc_t sat_min(input int unsigned w);
      return -sat_max(w) - gde_acc_t'(1);
   endfunction

   // Clamp v to the w-bit signed range when sat_en is set; otherwise pass it
   // through so that the caller's truncation to w bits wraps.
   function automatic gde_acc_t sat_trunc(input gde_acc_t v, input int unsigned w,
                                          input bit sat_en);
      if (sat_en && (v > sat_max(w))) return sat_max(w);
      if (sat_en && (v < sat_min(w))) return sat_min(w);
      return v;
   endfunction

endpackage

// File: rtl/gde_fxp_mul.sv
// Signed W x W fixed-point multiply with an arithmetic right shift by SHIFT.
// The full 2W-bit product is kept, so no precision is lost before the shift.
module gde_fxp_mul #(
   parameter int unsigned W     = 32,
   parameter int unsigned SHIFT = 0
) (
   input  logic signed [W-1:0]   a_i,
   input  logic signed [W-1:0]   b_i,
   output logic signed [2*W-1:0] p_o
);

   logic signed [2*W-1:0] prod;

   // Full-width product, then arithmetic shift (rounds toward minus infinity).
   always_comb begin
      prod = (2*W)'(a_i) * (2*W)'(b_i);
      p_o  = prod >>> SHIFT;
   end

endmodule

// File: rtl/gd_quad_engine.sv
// Fixed-point gradient-descent engine for y = a*x^2 + b*x + c.
// Runs up to iter_max descent iterations (early stop when |step| <= tol),
// then evaluates y at the final x. Start/busy/done handshake.
// Build option: define GDE_SAT_EN to saturate grad, step and the x update
// to the DATA_W signed range; otherwise these wrap. y_min never saturates.
module gd_quad_engine
   import gde_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FRAC_W = 8,
   parameter int unsigned ITER_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     x_init,
   input  logic [DATA_W-1:0]     coef_a,
   input  logic [DATA_W-1:0]     coef_b,
   input  logic [DATA_W-1:0]     coef_c,
   input  logic [DATA_W-1:0]     lr,
   input  logic [DATA_W-1:0]     tol,
   input  logic [ITER_W-1:0]     iter_max,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_W-1:0]     x_min,
   output logic [2*DATA_W-1:0]   y_min,
   output logic [ITER_W-1:0]     iter_count,
   output logic                  converged
);

   localparam int unsigned PW = 2 * DATA_W;

`ifdef GDE_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   gde_state_e state_q;
   logic signed [DATA_W-1:0] a_q, b_q, c_q, lr_q, tol_q, x_q, grad_q;
   logic [ITER_W-1:0]        itmax_q, iter_q;
   logic signed [PW-1:0]     x2_q, bx_q, y_q;
   logic                     busy_q, done_q, conv_q;

   logic signed [PW-1:0]     ax_sh, lrg_sh, x2_d, bx_d, grad_full, y_d;
   logic signed [DATA_W-1:0] grad_d, step, x_next;
   logic signed [DATA_W:0]   step_abs;
   logic                     step_small;
   logic [ITER_W-1:0]        iter_next;

   gde_fxp_mul #(.W(DATA_W), .SHIFT(FRAC_W - 1)) u_mul_grad (
      .a_i(a_q), .b_i(x_q), .p_o(ax_sh));

   gde_fxp_mul #(.W(DATA_W), .SHIFT(FRAC_W)) u_mul_step (
      .a_i(lr_q), .b_i(grad_q), .p_o(lrg_sh));

   gde_fxp_mul #(.W(DATA_W), .SHIFT(FRAC_W)) u_mul_x2 (
      .a_i(x_q), .b_i(x_q), .p_o(x2_d));

   gde_fxp_mul #(.W(DATA_W), .SHIFT(0)) u_mul_bx (
      .a_i(b_q), .b_i(x_q), .p_o(bx_d));

   // Gradient, step, x update, convergence test and y evaluation.
   always_comb begin
      grad_full  = ax_sh + PW'(b_q);
      grad_d     = DATA_W'(sat_trunc(gde_acc_t'(grad_full), DATA_W, SAT_EN));
      step       = DATA_W'(sat_trunc(gde_acc_t'(lrg_sh), DATA_W, SAT_EN));
      x_next     = DATA_W'(sat_trunc(gde_acc_t'(x_q) - gde_acc_t'(step), DATA_W, SAT_EN));
      step_abs   = step[DATA_W-1] ? -((DATA_W+1)'(step)) : (DATA_W+1)'(step);
      step_small = (step_abs <= (DATA_W+1)'(tol_q));
      iter_next  = iter_q + ITER_W'(1);
      y_d        = ((PW'(a_q) * x2_q + bx_q) >>> FRAC_W) + PW'(c_q);
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         lr_q    <= '0;
         tol_q   <= '0;
         itmax_q <= '0;
         x_q     <= '0;
         grad_q  <= '0;
         x2_q    <= '0;
         bx_q    <= '0;
         y_q     <= '0;
         iter_q  <= '0;
         conv_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= coef_a;
                  b_q     <= coef_b;
                  c_q     <= coef_c;
                  lr_q    <= lr;
                  tol_q   <= tol;
                  itmax_q <= iter_max;
                  x_q     <= x_init;
                  iter_q  <= '0;
                  conv_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= (iter_max == '0) ? S_EVAL1 : S_GRAD;
               end
            end
            S_GRAD: begin
               grad_q  <= grad_d;
               state_q <= S_UPDATE;
            end
            S_UPDATE: begin
               x_q    <= x_next;
               iter_q <= iter_next;
               if (step_small) begin
                  conv_q  <= 1'b1;
                  state_q <= S_EVAL1;
               end else if (iter_next == itmax_q) begin
                  state_q <= S_EVAL1;
               end else begin
                  state_q <= S_GRAD;
               end
            end
            S_EVAL1: begin
               x2_q    <= x2_d;
               bx_q    <= bx_d;
               state_q <= S_EVAL2;
            end
            S_EVAL2: begin
               y_q     <= y_d;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign x_min      = x_q;
   assign y_min      = y_q;
   assign iter_count = iter_q;
   assign converged  = conv_q;

endmodule
